// File: rtl/plot_stream_sink.sv
// Pixel-plot sink: buffers x/y/colour writes in a FIFO and replays one per clock to the vga_adapter.
// Latency: 2 clocks from accept into an empty FIFO to plot=1; sustained 1 pixel/clock.
// Backpressure: in_ready drops when full (no bypass); stall holds off draining, flush empties the FIFO.
// Optional: define PLOT_CLIP_EN to drop out-of-range pixels and count them in clip_count.
module plot_stream_sink #(
  parameter int DEPTH = 16,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 120
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_x,
  input  logic [6:0]                 in_y,
  input  logic [2:0]                 in_colour,
  output logic                       in_ready,
  input  logic                       stall,
  input  logic                       flush,
  output logic [7:0]                 x,
  output logic [6:0]                 y,
  output logic [2:0]                 colour,
  output logic                       plot,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 clip_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef PLOT_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pix_t;

  pix_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          accept;
  logic          oob;
  logic          store;
  logic          clip_hit;
  logic          pop;
  pix_t          head;

  // Ready depends only on registered occupancy; a full FIFO never accepts, even if popping.
  assign in_ready = reset_n && (level < LW'(DEPTH));

  // A flush edge discards whatever the producer presents, even with in_ready high.
  assign accept   = in_valid && in_ready && !flush;
  assign oob      = CLIP_EN && ((int'(in_x) >= X_MAX) || (int'(in_y) >= Y_MAX));
  assign store    = accept && !oob;
  assign clip_hit = accept && oob;
  assign pop      = !flush && !stall && (level != '0);
  assign head     = mem[rd_ptr];

  // Pixel storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= '{x: in_x, y: in_y, colour: in_colour};
    end
  end

  // Pointers and occupancy; flush has priority over push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Output pixel register: loads the head on a pop, otherwise holds with plot low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      plot <= pop;
      if (pop) begin
        x      <= head.x;
        y      <= head.y;
        colour <= head.colour;
      end
    end
  end

  // Saturating count of dropped out-of-range pixels; stays 0 when clipping is compiled out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_count <= '0;
    end else if (clip_hit && (clip_count != 8'hFF)) begin
      clip_count <= clip_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_plot_stream_sink.sv
// Directed self-checking bench for plot_stream_sink (DEPTH=16, 160x120).
// Inputs are driven and outputs sampled 1ns after each rising edge.
// Compile with PLOT_CLIP_EN defined to exercise the clipping checks.
module tb_plot_stream_sink;

  logic       clk;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_ready;
  logic       stall;
  logic       flush;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [4:0] level;
  logic [7:0] clip_count;

  int n_cmp  = 0;
  int n_fail = 0;

  plot_stream_sink #(.DEPTH(16), .X_MAX(160), .Y_MAX(120)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_colour  (in_colour),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .level      (level),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    in_valid  = v;
    in_x      = px;
    in_y      = py;
    in_colour = pc;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({x, y, colour, plot, level, clip_count, in_ready} !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b level=%0d clip=%0d rdy=%b, need all 0",
               x, y, colour, plot, level, clip_count, in_ready);
    end
    step();
    step();
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b level=%0d, need rdy=1 level=0", in_ready, level);
    end
  endtask

  task automatic test_single();
    drive(1'b1, 8'd50, 7'd30, 3'b101);
    step();
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    n_cmp++;
    if (level !== 5'd1 || plot !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got level=%0d plot=%b, need level=1 plot=0", level, plot);
    end
    step();
    n_cmp++;
    if (plot !== 1'b1 || x !== 8'd50 || y !== 7'd30 || colour !== 3'b101 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL single_plot: got plot=%b x=%0d y=%0d c=%b level=%0d, need 1 50 30 101 0",
               plot, x, y, colour, level);
    end
    step();
    n_cmp++;
    if (plot !== 1'b0 || x !== 8'd50) begin
      n_fail++;
      $display("FAIL single_after: got plot=%b x=%0d, need plot=0 x=50 held", plot, x);
    end
  endtask

  task automatic test_stall_full();
    int bad = 0;
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i + 1), 7'(i + 2), 3'(i));
      step();
      if (plot !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_plot_low: got %0d plot cycles while stalled, need 0", bad);
    end
    n_cmp++;
    if (level !== 5'd16 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_full: got level=%0d rdy=%b, need level=16 rdy=0", level, in_ready);
    end
    // Offer an extra pixel while full: must not be taken.
    drive(1'b1, 8'd99, 7'd99, 3'd7);
    step();
    n_cmp++;
    if (level !== 5'd16 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_accept: got level=%0d rdy=%b, need level=16 rdy=0", level, in_ready);
    end
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    stall = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      n_cmp++;
      if (plot !== 1'b1 || x !== 8'(i + 1) || y !== 7'(i + 2) || colour !== 3'(i)) begin
        n_fail++;
        $display("FAIL drain_%0d: got plot=%b x=%0d y=%0d c=%0d, need 1 %0d %0d %0d",
                 i, plot, x, y, colour, i + 1, i + 2, i % 8);
      end
    end
    step();
    n_cmp++;
    if (plot !== 1'b0 || in_ready !== 1'b1 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL drain_end: got plot=%b rdy=%b level=%0d, need 0 1 0", plot, in_ready, level);
    end
  endtask

  task automatic test_back_to_back();
    int bad_lvl = 0;
    for (int i = 0; i <= 40; i++) begin
      if (i < 40) drive(1'b1, 8'(i * 3), 7'(i + 5), 3'(i));
      else        drive(1'b0, 8'd0, 7'd0, 3'd0);
      step();
      if (level > 5'd1) bad_lvl++;
      if (i >= 1) begin
        n_cmp++;
        if (plot !== 1'b1 || x !== 8'((i - 1) * 3) || y !== 7'(i + 4) || colour !== 3'(i - 1)) begin
          n_fail++;
          $display("FAIL stream_%0d: got plot=%b x=%0d y=%0d c=%0d, need 1 %0d %0d %0d",
                   i - 1, plot, x, y, colour, (i - 1) * 3, i + 4, (i - 1) % 8);
        end
      end
    end
    n_cmp++;
    if (bad_lvl != 0) begin
      n_fail++;
      $display("FAIL stream_level: got %0d cycles with level>1, need 0", bad_lvl);
    end
    step();
    n_cmp++;
    if (plot !== 1'b0 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL stream_end: got plot=%b level=%0d, need 0 0", plot, level);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(10 + i), 7'(i), 3'(i));
      step();
    end
    n_cmp++;
    if (level !== 5'd5) begin
      n_fail++;
      $display("FAIL flush_fill: got level=%0d, need 5", level);
    end
    stall = 1'b0;
    flush = 1'b1;
    drive(1'b1, 8'd77, 7'd77, 3'd3);
    step();
    flush = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    n_cmp++;
    if (level !== 5'd0 || plot !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state: got level=%0d plot=%b rdy=%b, need 0 0 1", level, plot, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (plot === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL flush_discard: got %0d plots level=%0d after flush, need 0 0", seen, level);
    end
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(20 + i), 7'(40 + i), 3'(i));
      step();
    end
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    stall = 1'b0;
    step();
    n_cmp++;
    if (level !== 5'd7 || plot !== 1'b1 || x !== 8'd20) begin
      n_fail++;
      $display("FAIL mid_drain: got level=%0d plot=%b x=%0d, need 7 1 20", level, plot, x);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({x, y, colour, plot, level} !== 24'd0) begin
      n_fail++;
      $display("FAIL async_reset: got x=%0d y=%0d c=%0d plot=%b level=%0d, need all 0",
               x, y, colour, plot, level);
    end
    #1 reset_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL async_release: got rdy=%b level=%0d, need 1 0", in_ready, level);
    end
    step();
    n_cmp++;
    if (plot !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_plot: got plot=%b, need 0", plot);
    end
  endtask

  task automatic test_clip();
    int nplot = 0;
    logic [7:0] lx;
    logic [6:0] ly;
    int exp_plots;
    logic [7:0] exp_clip;
    lx = 8'd0;
    ly = 7'd0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       drive(1'b1, 8'd160, 7'd10,  3'd1);
        1:       drive(1'b1, 8'd10,  7'd120, 3'd2);
        2:       drive(1'b1, 8'd159, 7'd119, 3'd4);
        default: drive(1'b0, 8'd0,   7'd0,   3'd0);
      endcase
      step();
      if (plot === 1'b1) begin
        nplot++;
        lx = x;
        ly = y;
      end
    end
`ifdef PLOT_CLIP_EN
    exp_plots = 1;
    exp_clip  = 8'd2;
`else
    exp_plots = 3;
    exp_clip  = 8'd0;
`endif
    n_cmp++;
    if (nplot != exp_plots || lx !== 8'd159 || ly !== 7'd119) begin
      n_fail++;
      $display("FAIL clip_plots: got %0d plots last=(%0d,%0d), need %0d last=(159,119)",
               nplot, lx, ly, exp_plots);
    end
    n_cmp++;
    if (clip_count !== exp_clip) begin
      n_fail++;
      $display("FAIL clip_count: got %0d, need %0d", clip_count, exp_clip);
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 8'd200, 7'd5, 3'd6);
      step();
    end
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    step();
    step();
`ifdef PLOT_CLIP_EN
    exp_clip = 8'd255;
`else
    exp_clip = 8'd0;
`endif
    n_cmp++;
    if (clip_count !== exp_clip || level !== 5'd0) begin
      n_fail++;
      $display("FAIL clip_saturate: got clip=%0d level=%0d, need clip=%0d level=0",
               clip_count, level, exp_clip);
    end
  endtask

  initial begin
    reset_n = 1'b1;
    stall   = 1'b0;
    flush   = 1'b0;
    drive(1'b0, 8'd0, 7'd0, 3'd0);
    test_reset();
    test_single();
    test_stall_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_clip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
